// File: rtl/iob_timer_alarm_pkg.sv
// -----------------------------------------------------------------------------
// iob_timer_alarm_pkg
//
// Shared definitions for the timer compare/alarm stage:
//   - alarm_state_t : FSM state encoding (IDLE=0, ARMED=1, FIRED=2), which is
//                     also the encoding presented on state_o.
//   - default widths for the time value, auto-reload period and overrun
//     counter.
//
// Build option: defining IOB_TIMER_ALARM_PERIODIC_EN turns on auto-reload
// of the compare register in the top module.
// -----------------------------------------------------------------------------
package iob_timer_alarm_pkg;

    localparam int IOB_TIMER_ALARM_TIME_W   = 64;
    localparam int IOB_TIMER_ALARM_PERIOD_W = 32;
    localparam int IOB_TIMER_ALARM_OVR_W    = 8;

    typedef enum logic [1:0] {
        IOB_TIMER_ALARM_IDLE  = 2'd0,
        IOB_TIMER_ALARM_ARMED = 2'd1,
        IOB_TIMER_ALARM_FIRED = 2'd2
    } alarm_state_t;

endpackage : iob_timer_alarm_pkg

// File: rtl/iob_timer_alarm_cmp.sv
// -----------------------------------------------------------------------------
// iob_timer_alarm_cmp
//
// Combinational wrap-safe "time has reached target" test. The time value
// and the target are treated as points on a modular circle: the target
// counts as reached when the signed difference (time - target) is
// non-negative, i.e. when its MSB is clear. This stays correct across a
// wrap of the time counter as long as time is within 2^(TIME_W-1) of the
// target, and a time counter restarted at 0 with the target ahead does not
// produce a false hit.
//
// Ports:
//   time_i  [TIME_W-1:0]  current time
//   cmp_i   [TIME_W-1:0]  compare target
//   hit_o                 1 when time_i is at or past cmp_i (modular)
// -----------------------------------------------------------------------------
module iob_timer_alarm_cmp
    import iob_timer_alarm_pkg::*;
#(
    parameter int TIME_W = IOB_TIMER_ALARM_TIME_W
) (
    input  logic [TIME_W-1:0] time_i,
    input  logic [TIME_W-1:0] cmp_i,
    output logic              hit_o
);

    logic [TIME_W-1:0] w_diff;

    assign w_diff = time_i - cmp_i;
    assign hit_o  = ~w_diff[TIME_W-1];

endmodule : iob_timer_alarm_cmp

// File: rtl/iob_timer_alarm.sv
// -----------------------------------------------------------------------------
// iob_timer_alarm
//
// Compare/alarm stage fed by the free-running timer core. Holds a compare
// target, raises a level interrupt when time reaches it, keeps the
// interrupt pending until software acknowledges it, and counts alarms that
// arrive while a previous one is still pending (saturating).
//
// Build option:
//   IOB_TIMER_ALARM_PERIODIC_EN - when defined, a hit in ARMED with a
//   non-zero period advances the compare register by period_i and stays
//   ARMED (auto-reload). When undefined, period_i is ignored and every
//   alarm is one-shot.
//
// Ports:
//   clk_i      system clock
//   cke_i      clock enable; all state holds while low
//   arst_i     asynchronous active-high reset
//   time_i     current time from the timer core
//   cmp_i      new compare value
//   cmp_we_i   load cmp_i into the compare register
//   period_i   auto-reload period (periodic build only)
//   arm_i      pulse: enter ARMED
//   disarm_i   pulse: go to IDLE, clear pending and overrun count
//   ack_i      pulse: clear pending
//   irq_o      interrupt, equal to pending_o
//   pending_o  alarm pending
//   state_o    0=IDLE, 1=ARMED, 2=FIRED
//   ovr_cnt_o  saturating overrun count
// -----------------------------------------------------------------------------
module iob_timer_alarm
    import iob_timer_alarm_pkg::*;
#(
    parameter int TIME_W   = IOB_TIMER_ALARM_TIME_W,
    parameter int PERIOD_W = IOB_TIMER_ALARM_PERIOD_W,
    parameter int OVR_W    = IOB_TIMER_ALARM_OVR_W
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_i,
    input  logic [TIME_W-1:0]   time_i,
    input  logic [TIME_W-1:0]   cmp_i,
    input  logic                cmp_we_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                arm_i,
    input  logic                disarm_i,
    input  logic                ack_i,
    output logic                irq_o,
    output logic                pending_o,
    output logic [1:0]          state_o,
    output logic [OVR_W-1:0]    ovr_cnt_o
);

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (&v) ? v : v + OVR_W'(1);
    endfunction

    logic [TIME_W-1:0] r_cmp;
    alarm_state_t      r_state;
    logic              r_pending;
    logic [OVR_W-1:0]  r_ovr;

    logic              w_hit;
    logic              w_hit_armed;

    iob_timer_alarm_cmp #(
        .TIME_W (TIME_W)
    ) u_cmp (
        .time_i (time_i),
        .cmp_i  (r_cmp),
        .hit_o  (w_hit)
    );

    // Hits only matter while ARMED; IDLE and FIRED ignore the comparator.
    assign w_hit_armed = (r_state == IOB_TIMER_ALARM_ARMED) && w_hit;

`ifdef IOB_TIMER_ALARM_PERIODIC_EN
    logic              w_reload;
    logic [TIME_W-1:0] w_cmp_next;

    // A zero period degenerates to one-shot behaviour.
    assign w_reload   = |period_i;
    assign w_cmp_next = r_cmp + TIME_W'(period_i);
`else
    logic w_unused_period;

    assign w_unused_period = ^period_i;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_cmp     <= '0;
            r_state   <= IOB_TIMER_ALARM_IDLE;
            r_pending <= 1'b0;
            r_ovr     <= '0;
        end else if (cke_i) begin
            // Software load is honoured in every state; the comparison this
            // cycle still used the old target.
            if (cmp_we_i) begin
                r_cmp <= cmp_i;
            end

            if (disarm_i) begin
                r_state   <= IOB_TIMER_ALARM_IDLE;
                r_pending <= 1'b0;
                r_ovr     <= '0;
            end else if (w_hit_armed) begin
                // Setting pending beats a coincident ack, and an acked
                // overlap is not an overrun.
                r_pending <= 1'b1;
                if (r_pending && !ack_i) begin
                    r_ovr <= sat_inc(r_ovr);
                end
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
                if (w_reload) begin
                    r_state <= IOB_TIMER_ALARM_ARMED;
                    // A software load in the same cycle takes precedence
                    // over the automatic advance.
                    if (!cmp_we_i) begin
                        r_cmp <= w_cmp_next;
                    end
                end else begin
                    r_state <= IOB_TIMER_ALARM_FIRED;
                end
`else
                r_state <= IOB_TIMER_ALARM_FIRED;
`endif
            end else begin
                if (ack_i) begin
                    r_pending <= 1'b0;
                end
                // Re-arm from IDLE or FIRED; arming while ARMED is a no-op.
                if (arm_i && (r_state != IOB_TIMER_ALARM_ARMED)) begin
                    r_state <= IOB_TIMER_ALARM_ARMED;
                end
            end
        end
    end

    assign irq_o     = r_pending;
    assign pending_o = r_pending;
    assign state_o   = r_state;
    assign ovr_cnt_o = r_ovr;

endmodule : iob_timer_alarm

// File: tb/tb_iob_timer_alarm.sv
// -----------------------------------------------------------------------------
// tb_iob_timer_alarm
//
// Directed bench for iob_timer_alarm. Stimulus drives inputs on the falling
// edge and, after each rising edge, queues the hand-computed outputs that
// edge should produce; a separate monitor pops the queue on the next falling
// edge and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_iob_timer_alarm;

    localparam logic [63:0] ALL_F0 = 64'hFFFF_FFFF_FFFF_FFF0;
    localparam logic [63:0] ALL_E8 = 64'hFFFF_FFFF_FFFF_FFE8;
    localparam logic [63:0] ALL_EF = 64'hFFFF_FFFF_FFFF_FFEF;
    localparam logic [63:0] ALL_F8 = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk_i = 1'b0;
    logic        cke_i;
    logic        arst_i;
    logic [63:0] time_i;
    logic [63:0] cmp_i;
    logic        cmp_we_i;
    logic [31:0] period_i;
    logic        arm_i;
    logic        disarm_i;
    logic        ack_i;
    logic        irq_o;
    logic        pending_o;
    logic [1:0]  state_o;
    logic [7:0]  ovr_cnt_o;

    typedef struct {
        logic       pend;
        logic [1:0] st;
        logic [7:0] ovr;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    iob_timer_alarm dut (
        .clk_i     (clk_i),
        .cke_i     (cke_i),
        .arst_i    (arst_i),
        .time_i    (time_i),
        .cmp_i     (cmp_i),
        .cmp_we_i  (cmp_we_i),
        .period_i  (period_i),
        .arm_i     (arm_i),
        .disarm_i  (disarm_i),
        .ack_i     (ack_i),
        .irq_o     (irq_o),
        .pending_o (pending_o),
        .state_o   (state_o),
        .ovr_cnt_o (ovr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: compare every queued expectation at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_chk++;
                if (irq_o !== e.pend || pending_o !== e.pend ||
                    state_o !== e.st || ovr_cnt_o !== e.ovr) begin
                    n_fail++;
                    $display("FAIL %s: got irq=%0b pend=%0b state=%0d ovr=%0d, want irq=pend=%0b state=%0d ovr=%0d",
                             e.nm, irq_o, pending_o, state_o, ovr_cnt_o, e.pend, e.st, e.ovr);
                end
            end
        end
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // One clock: inputs already set; queue the post-edge expectation, then
    // return at the falling edge with pulses cleared.
    task automatic tick(input logic ep, input logic [1:0] es, input logic [7:0] eo, input string nm);
        exp_t e;
        @(posedge clk_i);
        e.pend = ep; e.st = es; e.ovr = eo; e.nm = nm;
        sb.push_back(e);
        @(negedge clk_i);
        arm_i    = 1'b0;
        disarm_i = 1'b0;
        ack_i    = 1'b0;
        cmp_we_i = 1'b0;
    endtask

    task automatic push_now(input logic ep, input logic [1:0] es, input logic [7:0] eo, input string nm);
        exp_t e;
        e.pend = ep; e.st = es; e.ovr = eo; e.nm = nm;
        sb.push_back(e);
    endtask

    initial begin
        int e_ovr;
        cke_i = 1'b1; arst_i = 1'b1; time_i = '0; cmp_i = '0; cmp_we_i = 1'b0;
        period_i = '0; arm_i = 1'b0; disarm_i = 1'b0; ack_i = 1'b0;

        // Reset state
        @(posedge clk_i); #1;
        push_now(1'b0, 2'd0, 8'd0, "reset");
        @(negedge clk_i);
        arst_i = 1'b0;

        // One-shot at cmp=100
        cmp_i = 64'd100; cmp_we_i = 1'b1; time_i = 64'd0;
        tick(1'b0, 2'd0, 8'd0, "load100");
        arm_i = 1'b1; time_i = 64'd1;
        tick(1'b0, 2'd1, 8'd0, "arm");
        time_i = 64'd99;
        tick(1'b0, 2'd1, 8'd0, "t99_nohit");
        time_i = 64'd100;
        tick(1'b1, 2'd2, 8'd0, "t100_hit");
        time_i = 64'd101;
        tick(1'b1, 2'd2, 8'd0, "fired_hold");

        // Pending held, re-arm, second hit counts overrun
        cmp_i = 64'd200; cmp_we_i = 1'b1; time_i = 64'd150;
        tick(1'b1, 2'd2, 8'd0, "load200");
        arm_i = 1'b1; time_i = 64'd160;
        tick(1'b1, 2'd1, 8'd0, "rearm_pend");
        time_i = 64'd199;
        tick(1'b1, 2'd1, 8'd0, "t199");
        time_i = 64'd200;
        tick(1'b1, 2'd2, 8'd1, "overrun");
        ack_i = 1'b1; time_i = 64'd201;
        tick(1'b0, 2'd2, 8'd1, "ack");
        time_i = 64'd202;
        tick(1'b0, 2'd2, 8'd1, "after_ack");

        // Wrap-around target
        disarm_i = 1'b1;
        tick(1'b0, 2'd0, 8'd0, "disarm_clr");
        cmp_i = ALL_F0; cmp_we_i = 1'b1; time_i = 64'd0;
        tick(1'b0, 2'd0, 8'd0, "loadF0");
        arm_i = 1'b1; time_i = ALL_E8;
        tick(1'b0, 2'd1, 8'd0, "wrap_E8");
        time_i = ALL_EF;
        tick(1'b0, 2'd1, 8'd0, "wrap_EF");
        time_i = ALL_F0;
        tick(1'b1, 2'd2, 8'd0, "wrap_hit");
        ack_i = 1'b1; time_i = ALL_F8;
        tick(1'b0, 2'd2, 8'd0, "wrap_ack");
        time_i = 64'd8;
        tick(1'b0, 2'd2, 8'd0, "wrap_after");

        // Timer restarted at 0 with target ahead: no spurious hit
        cmp_i = 64'd100; cmp_we_i = 1'b1; time_i = 64'd0;
        tick(1'b0, 2'd2, 8'd0, "load100b");
        arm_i = 1'b1;
        tick(1'b0, 2'd1, 8'd0, "arm_t0");
        time_i = 64'd5;
        tick(1'b0, 2'd1, 8'd0, "t5_nohit");

        // Hit with coincident ack, then hit with coincident disarm
        time_i = 64'd100;
        tick(1'b1, 2'd2, 8'd0, "hit_b");
        arm_i = 1'b1; time_i = 64'd101;
        tick(1'b1, 2'd1, 8'd0, "rearm_b");
        ack_i = 1'b1; time_i = 64'd102;
        tick(1'b1, 2'd2, 8'd0, "hit_ack");
        arm_i = 1'b1; time_i = 64'd103;
        tick(1'b1, 2'd1, 8'd0, "rearm_c");
        disarm_i = 1'b1; time_i = 64'd104;
        tick(1'b0, 2'd0, 8'd0, "hit_disarm");
        arm_i = 1'b1; time_i = 64'd105;
        tick(1'b0, 2'd1, 8'd0, "arm_idle_past");
        time_i = 64'd106;
        tick(1'b1, 2'd2, 8'd0, "hit_c");

        // Overrun saturation at 255
        e_ovr = 0;
        for (int i = 0; i < 260; i++) begin
            arm_i = 1'b1; time_i = 64'd107;
            tick(1'b1, 2'd1, 8'(e_ovr), "sat_arm");
            e_ovr = (e_ovr == 255) ? 255 : e_ovr + 1;
            time_i = 64'd108;
            tick(1'b1, 2'd2, 8'(e_ovr), "sat_hit");
        end

        // Clock enable low freezes state
        disarm_i = 1'b1;
        tick(1'b0, 2'd0, 8'd0, "disarm_sat");
        cke_i = 1'b0; arm_i = 1'b1;
        tick(1'b0, 2'd0, 8'd0, "cke_low");
        cke_i = 1'b1;

`ifdef IOB_TIMER_ALARM_PERIODIC_EN
        // Auto-reload: 50, 60, 70 then catch-up
        cmp_i = 64'd50; cmp_we_i = 1'b1; period_i = 32'd10; time_i = 64'd0;
        tick(1'b0, 2'd0, 8'd0, "p_load50");
        arm_i = 1'b1; time_i = 64'd49;
        tick(1'b0, 2'd1, 8'd0, "p_arm");
        time_i = 64'd50;
        tick(1'b1, 2'd1, 8'd0, "p_hit50");
        ack_i = 1'b1; time_i = 64'd51;
        tick(1'b0, 2'd1, 8'd0, "p_ack50");
        time_i = 64'd59;
        tick(1'b0, 2'd1, 8'd0, "p_t59");
        time_i = 64'd60;
        tick(1'b1, 2'd1, 8'd0, "p_hit60");
        ack_i = 1'b1; time_i = 64'd61;
        tick(1'b0, 2'd1, 8'd0, "p_ack60");
        time_i = 64'd70;
        tick(1'b1, 2'd1, 8'd0, "p_hit70");
        ack_i = 1'b1; time_i = 64'd71;
        tick(1'b0, 2'd1, 8'd0, "p_ack70");
        time_i = 64'd95;
        tick(1'b1, 2'd1, 8'd0, "p_catch80");
        tick(1'b1, 2'd1, 8'd1, "p_catch90");
        tick(1'b1, 2'd1, 8'd1, "p_caught");

        // Zero period acts as one-shot
        disarm_i = 1'b1;
        tick(1'b0, 2'd0, 8'd0, "p_disarm");
        period_i = 32'd0; cmp_i = 64'd200; cmp_we_i = 1'b1;
        tick(1'b0, 2'd0, 8'd0, "p_load200");
        arm_i = 1'b1;
        tick(1'b0, 2'd1, 8'd0, "p0_arm");
        time_i = 64'd200;
        tick(1'b1, 2'd2, 8'd0, "p0_hit");
        time_i = 64'd300;
        tick(1'b1, 2'd2, 8'd0, "p0_fired");

        // Software load wins over reload in the same cycle
        period_i = 32'd10; arm_i = 1'b1;
        tick(1'b1, 2'd1, 8'd0, "p_rearm");
        cmp_i = 64'd1000; cmp_we_i = 1'b1;
        tick(1'b1, 2'd1, 8'd1, "p_we_wins");
        tick(1'b1, 2'd1, 8'd1, "p_no_rehit");
        disarm_i = 1'b1;
        tick(1'b0, 2'd0, 8'd0, "p_disarm2");
        period_i = '0;
`endif

        // Async reset while a hit is imminent / pending
        cmp_i = 64'd1000; cmp_we_i = 1'b1; time_i = 64'd0;
        tick(1'b0, 2'd0, 8'd0, "r_load");
        arm_i = 1'b1; time_i = 64'd998;
        tick(1'b0, 2'd1, 8'd0, "r_arm");
        time_i = 64'd1000;
        tick(1'b1, 2'd2, 8'd0, "r_hit");
        @(posedge clk_i); #1;
        arst_i = 1'b1;
        #1;
        push_now(1'b0, 2'd0, 8'd0, "arst_immediate");
        @(negedge clk_i);
        arst_i = 1'b0; time_i = 64'd1001;
        tick(1'b0, 2'd0, 8'd0, "post_rst1");
        time_i = 64'd1002;
        tick(1'b0, 2'd0, 8'd0, "post_rst2");
        arm_i = 1'b1;
        tick(1'b0, 2'd1, 8'd0, "post_rst_arm");
        time_i = 64'd1003;
        tick(1'b1, 2'd2, 8'd0, "post_rst_hit");

        // Drain scoreboard (bounded)
        repeat (2) @(negedge clk_i);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_iob_timer_alarm
